// File: rtl/mipi_pkg.sv
// Shared constants, FSM state type and CRC helper for the CSI-2 packet framer
// and its receive-side counterparts.
package mipi_pkg;

    localparam logic [5:0]  DT_LONG_MIN = 6'h10;
    localparam logic [15:0] CRC_SEED    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'h8408;
    localparam int          SOT_CYC_DEF = 4;
    localparam int          EOT_CYC_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOT,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC,
        ST_EOT
    } state_e;

    // Reflected CRC-16 over the enabled bytes of one word, byte 0 first, LSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [31:0] data,
                                               input logic [3:0]  be);
        logic [15:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                for (int i = 0; i < 8; i++) begin
                    if (c[0] ^ data[8*b+i]) c = (c >> 1) ^ CRC_POLY;
                    else                    c = c >> 1;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mipi_ecc_gen.sv
// CSI-2 packet header ECC: 6 Hamming parity bits over the 24-bit {WC, DI} field.
// Purely combinational so the receive-side header checker can share it.
module mipi_ecc_gen (
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);

    logic [23:0] d;
    assign d = data_i;

    assign ecc_o[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
                      d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    assign ecc_o[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
                      d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    assign ecc_o[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
                      d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
    assign ecc_o[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
                      d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
    assign ecc_o[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
                      d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
    assign ecc_o[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
                      d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];

endmodule

// File: rtl/mipi_lpkt_tx.sv
// CSI-2 long/short packet framer onto the 32-bit HS word bus: SOT, header+ECC,
// payload, checksum, EOT. Define MIPI_LPKT_TX_CRC_EN to compute the payload CRC.
module mipi_lpkt_tx
    import mipi_pkg::*;
#(
    parameter int SOT_CYC = SOT_CYC_DEF,
    parameter int EOT_CYC = EOT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  di,
    input  logic [15:0] wc,
    input  logic [31:0] in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [31:0] dout,
    output logic        dout_vld,
    output logic [3:0]  dout_be,
    output logic        lp_out,
    output logic        busy,
    output logic        pkt_end,
    output logic        err_underrun
);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic [15:0] rem_q;
    logic        in_rdy_q;
    logic [31:0] dout_q;
    logic        dout_vld_q;
    logic [3:0]  dout_be_q;
    logic        lp_q;
    logic        busy_q;
    logic        pkt_end_q;
    logic        err_q;

    logic [5:0]  ecc_d;
    logic        is_short_d;
    logic        last_word_d;
    logic        accept_d;
    logic        crc_go_d;
    logic [3:0]  word_be_d;
    logic [31:0] word_d;
    logic [15:0] crc_word_d;

    mipi_ecc_gen u_ecc (
        .data_i ({wc_q, di_q}),
        .ecc_o  (ecc_d)
    );

    assign is_short_d  = (di_q[5:0] < DT_LONG_MIN);
    // rem_q is never zero while in_rdy is high, so <= 4 marks the final word
    assign last_word_d = (rem_q <= 16'd4);
    assign accept_d    = in_rdy_q & in_vld;
    assign crc_go_d    = ((state_q == ST_HDR) && !is_short_d && (wc_q == 16'd0)) ||
                         ((state_q == ST_PAYLOAD) && !in_rdy_q);

    always_comb begin
        word_be_d = 4'b1111;
        if (last_word_d) begin
            case (rem_q[2:0])
                3'd1:    word_be_d = 4'b0001;
                3'd2:    word_be_d = 4'b0011;
                3'd3:    word_be_d = 4'b0111;
                default: word_be_d = 4'b1111;
            endcase
        end
        word_d = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (word_be_d[b]) word_d[8*b +: 8] = in_data[8*b +: 8];
        end
    end

`ifdef MIPI_LPKT_TX_CRC_EN
    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE) crc_q <= CRC_SEED;
        else if (accept_d)      crc_q <= crc16_word(crc_q, in_data, word_be_d);
    end

    assign crc_word_d = crc_q;
`else
    assign crc_word_d = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            in_rdy_q   <= 1'b0;
            dout_q     <= 32'h0;
            dout_vld_q <= 1'b0;
            dout_be_q  <= 4'h0;
            lp_q       <= 1'b1;
            busy_q     <= 1'b0;
            pkt_end_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pkt_end_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        di_q    <= di;
                        wc_q    <= wc;
                        rem_q   <= wc;
                        cnt_q   <= 4'(SOT_CYC - 1);
                        lp_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SOT;
                    end
                end
                ST_SOT: begin
                    if (cnt_q == 4'd0) begin
                        dout_q     <= {2'b00, ecc_d, wc_q[15:8], wc_q[7:0], di_q};
                        dout_be_q  <= 4'b1111;
                        dout_vld_q <= 1'b1;
                        // ready goes up with the header so the first word lands right after it
                        in_rdy_q   <= !is_short_d && (wc_q != 16'd0);
                        state_q    <= ST_HDR;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HDR: begin
                    if (is_short_d) begin
                        cnt_q     <= 4'(EOT_CYC - 1);
                        pkt_end_q <= (EOT_CYC == 1);
                        state_q   <= ST_EOT;
                    end else if (wc_q == 16'd0) begin
                        state_q <= ST_CRC;
                    end else begin
                        state_q <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!in_rdy_q) state_q <= ST_CRC;
                end
                ST_CRC: begin
                    cnt_q     <= 4'(EOT_CYC - 1);
                    pkt_end_q <= (EOT_CYC == 1);
                    state_q   <= ST_EOT;
                end
                ST_EOT: begin
                    if (cnt_q == 4'd0) begin
                        lp_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q     <= cnt_q - 4'd1;
                        pkt_end_q <= (cnt_q == 4'd1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Output word for the next cycle: payload, underrun gap, checksum or idle
            if (accept_d) begin
                dout_q     <= word_d;
                dout_be_q  <= word_be_d;
                dout_vld_q <= 1'b1;
                rem_q      <= last_word_d ? 16'd0 : rem_q - 16'd4;
                if (last_word_d) in_rdy_q <= 1'b0;
            end else if (in_rdy_q) begin
                dout_q     <= 32'h0;
                dout_be_q  <= 4'h0;
                dout_vld_q <= 1'b0;
                err_q      <= 1'b1;
            end else if (crc_go_d) begin
                dout_q     <= {16'h0, crc_word_d};
                dout_be_q  <= 4'b0011;
                dout_vld_q <= 1'b1;
            end else if ((state_q == ST_HDR) || (state_q == ST_CRC)) begin
                dout_q     <= 32'h0;
                dout_be_q  <= 4'h0;
                dout_vld_q <= 1'b0;
            end
        end
    end

    assign in_rdy       = in_rdy_q;
    assign dout         = dout_q;
    assign dout_vld     = dout_vld_q;
    assign dout_be      = dout_be_q;
    assign lp_out       = lp_q;
    assign busy         = busy_q;
    assign pkt_end      = pkt_end_q;
    assign err_underrun = err_q;

endmodule

// File: tb/tb_mipi_lpkt_tx.sv
// Directed bench for mipi_lpkt_tx: table of packet vectors plus a mid-packet reset sequence.
// Expected CRC follows MIPI_LPKT_TX_CRC_EN (0x0000 when the macro is undefined).
module tb_mipi_lpkt_tx;

    localparam int SOT = 4;
    localparam int EOT = 3;
    localparam int H   = 1 + SOT;

    logic        clk = 1'b0;
    logic        reset_n, start, in_vld, in_rdy;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [31:0] in_data, dout;
    logic        dout_vld, lp_out, busy, pkt_end, err_underrun;
    logic [3:0]  dout_be;

    always #5 clk = ~clk;

    mipi_lpkt_tx #(.SOT_CYC(SOT), .EOT_CYC(EOT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .di(di), .wc(wc),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_be(dout_be), .lp_out(lp_out),
        .busy(busy), .pkt_end(pkt_end), .err_underrun(err_underrun)
    );

    typedef struct {
        logic [7:0]  di;
        logic [15:0] wc;
        int          gap;
        logic [31:0] hdr;
        logic [3:0]  last_be;
        int          nw;
        bit          has_hand;
        logic [15:0] crc_hand;
    } vec_t;

    vec_t vecs[7];

    logic [7:0] sb [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                            8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                            8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    logic [5:0] syn [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                             6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                             6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    int tests = 0;
    int fails = 0;

    logic [31:0] outw[$];
    logic [3:0]  outbe[$];
    int          outrel[$];
    int          err_cnt, pe_rel;
    logic        lp_after, busy_after;
    bit          done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pay_word(input int k);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = sb[(4*k + j) % 24];
        return w;
    endfunction

    function automatic logic [5:0] ecc_model(input logic [23:0] d);
        logic [5:0] e = 6'h0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= syn[i];
        return e;
    endfunction

    // Byte-wise reflected CCITT update, independent of a bit-serial formulation
    function automatic logic [15:0] crc_model(input int nbytes);
        logic [15:0] c = 16'hFFFF;
        logic [7:0]  x;
        for (int b = 0; b < nbytes; b++) begin
            x = c[7:0] ^ sb[b % 24];
            x = x ^ (x << 4);
            c = {8'h00, c[15:8]} ^ {x, 8'h00} ^ {5'b0, x, 3'b0} ^ {12'h0, x[7:4]};
        end
        return c;
    endfunction

    task automatic run_pkt(input vec_t v);
        int  rel = 0;
        int  idx = 0;
        bit  acc = 0;
        int  g0  = H + 2;
        int  bound = v.nw + SOT + EOT + v.gap + 40;
        outw.delete(); outbe.delete(); outrel.delete();
        err_cnt = 0; pe_rel = -1; done = 0;
        di = v.di; wc = v.wc; start = 1'b1; in_vld = 1'b0;
        while (!done && rel < bound) begin
            @(posedge clk); #1;
            rel++;
            start = 1'b0;
            if (acc) idx++;
            in_vld  = (idx < v.nw) && !(rel >= g0 && rel < g0 + v.gap);
            in_data = pay_word(idx);
            @(negedge clk);
            acc = in_vld && in_rdy;
            if (dout_vld) begin
                outw.push_back(dout); outbe.push_back(dout_be); outrel.push_back(rel);
            end
            if (err_underrun) err_cnt++;
            if (pe_rel >= 0 && rel == pe_rel + 1) begin
                lp_after = lp_out; busy_after = busy; done = 1;
            end
            if (pkt_end) pe_rel = rel;
        end
        in_vld = 1'b0;
    endtask

    task automatic check_pkt(input vec_t v);
        bit          is_short = (v.di[5:0] < 6'h10);
        int          nexp = is_short ? 1 : v.nw + 2;
        int          pe_exp = is_short ? H + EOT : H + v.nw + v.gap + 1 + EOT;
        logic [15:0] crc_exp;
        logic [3:0]  ebe;
        logic [31:0] ew, m;
        bit          bad = 0;
        int          n;
`ifdef MIPI_LPKT_TX_CRC_EN
        crc_exp = crc_model(v.wc);
`else
        crc_exp = 16'h0000;
`endif
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout: no pkt_end for di=%0h wc=%0h", v.di, v.wc);
            return;
        end
        n = outw.size();
        chk("word_count", 64'(n), 64'(nexp));
        if (n < 1) return;
        chk("hdr", {outw[0], 28'h0, outbe[0]}, {v.hdr, 28'h0, 4'hF});
        chk("hdr_cycle", 64'(outrel[0]), 64'(H));
        chk("ecc_model", 64'(outw[0][31:24]), {58'h0, ecc_model({v.wc, v.di})});
        chk("pkt_end_cycle", 64'(pe_rel), 64'(pe_exp));
        chk("underruns", 64'(err_cnt), 64'(v.gap));
        chk("lp_after", {lp_after, busy_after}, 64'b10);
        if (is_short || n != nexp) return;
        for (int i = 0; i < v.nw; i++) begin
            ebe = (i == v.nw - 1) ? v.last_be : 4'hF;
            for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{ebe[b]}};
            ew = pay_word(i) & m;
            if (!bad && (outw[1+i] !== ew || outbe[1+i] !== ebe)) begin
                bad = 1;
                $display("FAIL payload word %0d: got %h/%b expected %h/%b", i, outw[1+i], outbe[1+i], ew, ebe);
            end
        end
        tests++;
        if (bad) fails++;
        chk("crc_word", {outw[n-1], 28'h0, outbe[n-1]}, {16'h0, crc_exp, 28'h0, 4'b0011});
        if (v.has_hand) begin
`ifdef MIPI_LPKT_TX_CRC_EN
            chk("crc_hand", 64'(outw[n-1]), {48'h0, v.crc_hand});
`else
            chk("crc_hand", 64'(outw[n-1]), 64'h0);
`endif
        end
    endtask

    initial begin
        vecs[0] = '{8'h2B, 16'd24,    0, 32'h1400182B, 4'hF, 6,     1, 16'h00F0};
        vecs[1] = '{8'h2B, 16'd5,     0, 32'h2E00052B, 4'h1, 2,     0, 16'h0000};
        vecs[2] = '{8'h00, 16'h0001,  0, 32'h1A000100, 4'h0, 0,     0, 16'h0000};
        vecs[3] = '{8'h2B, 16'd24,    3, 32'h1400182B, 4'hF, 6,     1, 16'h00F0};
        vecs[4] = '{8'h12, 16'd0,     0, 32'h18000012, 4'h0, 0,     1, 16'hFFFF};
        vecs[5] = '{8'h2B, 16'd7,     0, 32'h3200072B, 4'h7, 2,     0, 16'h0000};
        vecs[6] = '{8'h2B, 16'hFFFF,  0, 32'h2DFFFF2B, 4'h7, 16384, 0, 16'h0000};

        reset_n = 1'b0; start = 1'b0; in_vld = 1'b0; di = 8'h0; wc = 16'h0; in_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {in_rdy, dout, dout_vld, dout_be, lp_out, busy, pkt_end, err_underrun},
            {1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_pkt(vecs[i]);
            check_pkt(vecs[i]);
        end

        // Reset in the middle of the payload, then a clean packet
        di = 8'h2B; wc = 16'd24; start = 1'b1;
        for (int k = 1; k <= H + 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0; in_vld = 1'b1; in_data = pay_word(k);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_payload", {lp_out, busy, in_rdy, dout_vld}, 64'b1000);
        @(posedge clk); #1;
        reset_n = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        run_pkt(vecs[0]);
        check_pkt(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mipi_lpkt_tx.md
Name: mipi_lpkt_tx

Overview:
- Transmit-side counterpart of the receive-path payload end/word-count checker.
- Frames a CSI-2 long packet (or a short packet) onto the 32-bit HS word bus. Sequence: packet header with ECC, payload words pulled from an upstream stream, 16-bit checksum, then LP/HS trail.
- Sits between the pixel packer and the lane distributor.
- Word-count tracking mirrors the receiver: 4 bytes per word, and the final word is partial when WC mod 4 != 0.

Parameters:
- SOT_CYC, 4, HS-prepare/sync cycles between leaving LP and the header word (1..15).
- EOT_CYC, 3, HS-trail cycles after the last data word before returning to LP (1..15).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  packet request; sampled only in IDLE.
- di  in  8  data identifier (VC[7:6], DT[5:0]); captured on accepted start.
- wc  in  16  payload byte count (long) or short-packet data field; captured on accepted start.
- in_data  in  32  payload word, byte 0 in [7:0].
- in_vld  in  1  payload word valid.
- in_rdy  out  1  payload word accepted when in_vld & in_rdy.
- dout  out  32  HS word to lane distributor, byte 0 in [7:0].
- dout_vld  out  1  dout carries packet bytes this cycle.
- dout_be  out  4  byte enables for dout.
- lp_out  out  1  1 = lanes in LP-11, 0 = HS active.
- busy  out  1  high in every state except IDLE.
- pkt_end  out  1  one-cycle pulse on the last EOT cycle.
- err_underrun  out  1  one-cycle pulse when PAYLOAD needs a word and in_vld = 0.

Behaviour:
- Reset values: in_rdy=0, dout=0, dout_vld=0, dout_be=0, lp_out=1, busy=0, pkt_end=0, err_underrun=0; state=IDLE.
- Reset mid-packet aborts immediately to these values; no trail is sent.
- Outputs are registered. No output backpressure exists; an HS link cannot stall.

State machine (IDLE, SOT, HDR, PAYLOAD, CRC, EOT):
- IDLE: lp_out=1. On start: capture di/wc, go to SOT. start in any other state is ignored.
- SOT: lp_out=0, dout_vld=0, for SOT_CYC cycles, then HDR.
- HDR: one cycle. dout={ecc, wc[15:8], wc[7:0], di}, be=1111, vld=1. ecc = 8 bits: 2'b00 + 6-bit CSI-2 ECC over {wc, di}.
  - Short packet (DT < 0x10): go to EOT.
  - Long packet with wc=0: go to CRC.
  - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - in_rdy=1.
  - Each accepted word is forwarded the next cycle with vld=1, and the byte counter (16-bit) advances by 4.
  - Last word: remaining bytes <= 4. Its be = 1111 if wc[1:0]==0, else a low-bit mask of wc[1:0] bytes; unused bytes are driven 0.
  - in_rdy drops the cycle after the last word is accepted, then go to CRC.
  - If in_vld=0: dout_vld=0, err_underrun pulses, state holds.
- CRC: one cycle. dout={16'h0, crc}, be=0011, vld=1, then EOT.
  - CRC-16: poly x^16+x^12+x^5+1, LSB-first (reflected 0x8408), seed 0xFFFF.
  - Covers exactly wc bytes; disabled bytes are excluded. Updated 4 bytes/cycle.
- EOT: lp_out=0, vld=0, for EOT_CYC cycles; pkt_end on the last cycle. Next state IDLE; lp_out=1 the following cycle.
- Latency: start at cycle T → HDR word at T+1+SOT_CYC.
- Byte counter: 16-bit. wc=0xFFFF must not overflow the compare; compare the remaining count, not wc-const.

Optional Feature:
- Macro MIPI_LPKT_TX_CRC_EN.
  - Defined: checksum computed as above.
  - Undefined: CRC logic is removed and the CRC word carries 0x0000 (CSI-2 "checksum not computed"); state timing is identical.

Decomposition:
- Package mipi_pkg: DT short/long boundary (0x10), CRC seed and polynomial, state enum, SOT/EOT default constants.
- Sub-module mipi_ecc_gen: combinational 24-bit → 6-bit Hamming ECC per CSI-2. Reusable by the receive-side header checker.

Test Plan:
- Long packet: di=0x2B, wc=24, payload bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → 6 payload words all be=1111; CRC word 0x000000F0; pkt_end at T+1+SOT_CYC+1+6+1+EOT_CYC-1.
- wc=5 → 2 payload words, second be=0001 with upper bytes 0; CRC over 5 bytes matches model.
- Short packet: di=0x00, wc=0x0001 → single HDR word with ECC from model, no CRC, lp_out back to 1 after EOT.
- in_vld deasserted 3 cycles mid-PAYLOAD → 3 err_underrun pulses, 3 dout_vld gaps, payload/CRC unchanged.
- reset_n low during PAYLOAD → next cycle lp_out=1, busy=0, in_rdy=0; following start produces a clean packet.
- Macro undefined: wc=24 packet → CRC word 0x00000000, cycle count identical to the first case.
